alu_seq: RTL

//  Parametrised, handshaked successor to the single-cycle datapath ALU for the RISC core's execute stage.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_muldiv.sv | 92 +++++++++
 rtl/alu_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag payload for the sequential execute-stage ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

    // Opcodes served by the iterative multiplier/divider.
    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the execute stage and the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Carry;
    logic             OverFlow;
    logic             Zero;
    logic             Negative;
    logic             busy;

    modport master (
        output in_valid, A, B, ALUControl, out_ready,
        input  in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative, busy
    );

    modport slave (
        input  in_valid, A, B, ALUControl, out_ready,
        output in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative, busy
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module alu_seq_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W1 = WIDTH + 1;

    logic             active_q, active_d;
    logic             is_div_q, is_div_d;
    logic             done_q, done_d;
    logic [CW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [W1-1:0]    mul_sum_c;
    logic [W1-1:0]    div_shift_c;
    logic [W1-1:0]    div_diff_c;
    logic             div_ge_c;

    // {hi,lo} is the product register for MUL and the {remainder,quotient} pair for DIV.
    always_comb begin
        mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : W1'(0));
        div_shift_c = {hi_q, lo_q[WIDTH-1]};
        div_ge_c    = div_shift_c >= {1'b0, b_q};
        div_diff_c  = div_shift_c - {1'b0, b_q};

        active_d = active_q;
        is_div_d = is_div_q;
        step_d   = step_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        b_d      = b_q;
        done_d   = 1'b0;

        if (start_i) begin
            active_d = 1'b1;
            is_div_d = is_div_i;
            step_d   = '0;
            lo_d     = a_i;
            hi_d     = '0;
            b_d      = b_i;
        end else if (active_q) begin
            if (is_div_q) begin
                hi_d = div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge_c};
            end else begin
                {hi_d, lo_d} = {mul_sum_c, lo_q[WIDTH-1:1]};
            end
            step_d = step_q + CW'(1);
            if (step_q == CW'(WIDTH - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            is_div_q <= 1'b0;
            done_q   <= 1'b0;
            step_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            b_q      <= '0;
        end else begin
            active_q <= active_d;
            is_div_q <= is_div_d;
            done_q   <= done_d;
            step_q   <= step_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            b_q      <= b_d;
        end
    end

    assign done_o = done_q;
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned W1  = WIDTH + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q;
    logic             busy_q;

    logic             accept_c;
    logic             md_start_c;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi, md_res_c;

    logic             sub_c, ovf_c;
    logic [WIDTH-1:0] addend_c;
    logic [W1-1:0]    sum_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] sc_result_c;
    logic             sc_carry_c, sc_ovf_c;

    logic             load_c;
    logic [WIDTH-1:0] load_val_c;
    logic             load_carry_c, load_ovf_c;

    assign accept_c   = bus.in_valid && (state_q == S_IDLE);
    assign md_start_c = accept_c && is_iter(bus.ALUControl);
    assign md_res_c   = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? md_lo : md_hi;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start_c),
        .is_div_i (is_div(bus.ALUControl)),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .done_o   (md_done),
        .lo_o     (md_lo),
        .hi_o     (md_hi)
    );

    // Single-cycle datapath on the latched operands; SUB/SLT share one adder via A + ~B + 1.
    always_comb begin
        sub_c    = (op_q == OP_SUB) || (op_q == OP_SLT);
        addend_c = sub_c ? ~b_q : b_q;
        sum_c    = {1'b0, a_q} + {1'b0, addend_c} + W1'(sub_c);
        ovf_c    = (a_q[WIDTH-1] == addend_c[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
        shamt_c  = b_q[SHW-1:0];

        sc_result_c = '0;
        sc_carry_c  = 1'b0;
        sc_ovf_c    = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                sc_result_c = sum_c[WIDTH-1:0];
                sc_carry_c  = sum_c[WIDTH];
                sc_ovf_c    = ovf_c;
            end
            OP_AND: sc_result_c = a_q & b_q;
            OP_OR:  sc_result_c = a_q | b_q;
            OP_XOR: sc_result_c = a_q ^ b_q;
            OP_SLT: begin
                sc_result_c = WIDTH'(sum_c[WIDTH-1] ^ ovf_c);
                sc_carry_c  = sum_c[WIDTH];
                sc_ovf_c    = ovf_c;
            end
            OP_SLL: sc_result_c = a_q << shamt_c;
            OP_SRL: sc_result_c = a_q >> shamt_c;
            OP_SRA: sc_result_c = WIDTH'($signed(a_q) >>> shamt_c);
            default: sc_result_c = '0;
        endcase
    end

    // FSM next state; the result register loads once per operation, on entry to out_valid.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        out_valid_d  = out_valid_q;
        load_c       = 1'b0;
        load_val_c   = sc_result_c;
        load_carry_c = sc_carry_c;
        load_ovf_c   = sc_ovf_c;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.ALUControl;
                    state_d = is_iter(bus.ALUControl) ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (md_done) begin
                    load_c       = 1'b1;
                    load_val_c   = md_res_c;
                    load_carry_c = 1'b0;
                    load_ovf_c   = 1'b0;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    load_c = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_c) begin
            out_valid_d = 1'b1;
        end
        result_d = load_c ? load_val_c : result_q;
        flags_d  = load_c ? '{carry:    load_carry_c,
                              overflow: load_ovf_c,
                              zero:     (load_val_c == '0),
                              negative: load_val_c[WIDTH-1]}
                          : flags_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Carry     = flags_q.carry;
    assign bus.OverFlow  = flags_q.overflow;
    assign bus.Zero      = flags_q.zero;
    assign bus.Negative  = flags_q.negative;

endmodule
